// File: rtl/term_pkg.sv
// ============================================================================
// Module      : term_pkg
// Description : Shared constants, widths and state encoding for the terminal
//               VRAM writer and the text renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package term_pkg;

    localparam int COL_W = 6;
    localparam int ROW_W = 5;
    localparam int AD_W  = COL_W + ROW_W;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef logic [1:0] term_state_t;

    localparam term_state_t ST_IDLE     = 2'd0;
    localparam term_state_t ST_PUT      = 2'd1;
    localparam term_state_t ST_CLR_LINE = 2'd2;
    localparam term_state_t ST_CLR_ALL  = 2'd3;

    function automatic logic is_printable(input logic [7:0] b);
        return ((b >= 8'h20) && (b <= 8'h7E)) || (b >= 8'hA0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/term_clr_seq.sv
// ============================================================================
// Module      : term_clr_seq
// Description : Address generator for line and full-screen blank fills.
//               Presents the next write each cycle; done marks the final one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module term_clr_seq
    import term_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_line,
    input  logic              start_all,
    input  logic [ROW_W-1:0]  row,
    output logic              wr_nxt,
    output logic              done,
    output logic [AD_W-1:0]   nxt_ad
);

    logic              active_q,   active_d;
    logic              mode_all_q, mode_all_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic [COL_W-1:0]  line_cnt_q, line_cnt_d;
    logic [AD_W-1:0]   all_cnt_q,  all_cnt_d;
    logic              last;

    always_comb begin
        active_d   = active_q;
        mode_all_d = mode_all_q;
        row_d      = row_q;
        line_cnt_d = line_cnt_q;
        all_cnt_d  = all_cnt_q;
        wr_nxt     = 1'b0;
        nxt_ad     = '0;
        // Terminal count is the all-ones value of the counter in use.
        last       = mode_all_q ? (&all_cnt_q) : (&line_cnt_q);
        done       = active_q && last;

        if (start_all) begin
            active_d   = 1'b1;
            mode_all_d = 1'b1;
            all_cnt_d  = '0;
            wr_nxt     = 1'b1;
            nxt_ad     = '0;
        end else if (start_line) begin
            active_d   = 1'b1;
            mode_all_d = 1'b0;
            row_d      = row;
            line_cnt_d = '0;
            wr_nxt     = 1'b1;
            nxt_ad     = {row, {COL_W{1'b0}}};
        end else if (active_q) begin
            if (last) begin
                active_d = 1'b0;
            end else begin
                wr_nxt = 1'b1;
                if (mode_all_q) begin
                    all_cnt_d = all_cnt_q + AD_W'(1);
                    nxt_ad    = all_cnt_d;
                end else begin
                    line_cnt_d = line_cnt_q + COL_W'(1);
                    nxt_ad     = {row_q, line_cnt_d};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            mode_all_q <= 1'b0;
            row_q      <= '0;
            line_cnt_q <= '0;
            all_cnt_q  <= '0;
        end else begin
            active_q   <= active_d;
            mode_all_q <= mode_all_d;
            row_q      <= row_d;
            line_cnt_q <= line_cnt_d;
            all_cnt_q  <= all_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_term_writer.sv
// ============================================================================
// Module      : vram_term_writer
// Description : Terminal byte interpreter driving VRAM port A; tracks the
//               cursor and scroll offset consumed by the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_term_writer
    import term_pkg::*;
#(
    parameter int         COLS  = 64,
    parameter int         ROWS  = 32,
    parameter logic [7:0] BLANK = 8'h20
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              vram_ce,
    output logic              vram_wre,
    output logic [AD_W-1:0]   vram_ad,
    output logic [7:0]        vram_din,
    output logic [ROW_W-1:0]  top_row,
    output logic [COL_W-1:0]  cur_col,
    output logic [ROW_W-1:0]  cur_row,
    output logic              busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    term_state_t       state_q,       state_d;
    logic              rx_ready_q,    rx_ready_d;
    logic              busy_q,        busy_d;
    logic              vram_ce_q,     vram_ce_d;
    logic [AD_W-1:0]   vram_ad_q,     vram_ad_d;
    logic [7:0]        vram_din_q,    vram_din_d;
    logic [ROW_W-1:0]  top_row_q,     top_row_d;
    logic [COL_W-1:0]  cur_col_q,     cur_col_d;
    logic [ROW_W-1:0]  cur_row_q,     cur_row_d;
    logic              scroll_pend_q, scroll_pend_d;

    logic              accept;
    logic              put_wr;
    logic              start_line;
    logic              start_all;
    logic [ROW_W-1:0]  line_row;
    logic [ROW_W-1:0]  phys;
    logic              clr_wr;
    logic              clr_done;
    logic [AD_W-1:0]   clr_ad;

    term_clr_seq u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_line (start_line),
        .start_all  (start_all),
        .row        (line_row),
        .wr_nxt     (clr_wr),
        .done       (clr_done),
        .nxt_ad     (clr_ad)
    );

    always_comb begin
        state_d       = state_q;
        rx_ready_d    = rx_ready_q;
        busy_d        = busy_q;
        top_row_d     = top_row_q;
        cur_col_d     = cur_col_q;
        cur_row_d     = cur_row_q;
        scroll_pend_d = scroll_pend_q;
        vram_ad_d     = vram_ad_q;
        vram_din_d    = vram_din_q;
        put_wr        = 1'b0;
        start_line    = 1'b0;
        start_all     = 1'b0;
        line_row      = top_row_q;
        accept        = rx_valid && rx_ready_q;
        phys          = cur_row_q + top_row_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rx_ready_d = 1'b0;
                    state_d    = ST_PUT;
                    if (is_printable(rx_data)) begin
                        put_wr = 1'b1;
                        if (cur_col_q != LAST_COL) begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end else begin
                            cur_col_d = '0;
                            if (cur_row_q != LAST_ROW) begin
                                cur_row_d = cur_row_q + ROW_W'(1);
                            end else begin
                                top_row_d     = top_row_q + ROW_W'(1);
                                scroll_pend_d = 1'b1;
                            end
                        end
                    end else begin
                        case (rx_data)
                            CH_LF: begin
                                if (cur_row_q != LAST_ROW) begin
                                    cur_row_d = cur_row_q + ROW_W'(1);
                                end else begin
                                    // New bottom row is the old top row.
                                    top_row_d  = top_row_q + ROW_W'(1);
                                    start_line = 1'b1;
                                    line_row   = top_row_q;
                                    state_d    = ST_CLR_LINE;
                                    busy_d     = 1'b1;
                                end
                            end
                            CH_CR: cur_col_d = '0;
                            CH_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - COL_W'(1);
                                end
                            end
                            CH_FF: begin
                                top_row_d = '0;
                                cur_col_d = '0;
                                cur_row_d = '0;
                                start_all = 1'b1;
                                state_d   = ST_CLR_ALL;
                                busy_d    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                if (scroll_pend_q) begin
                    // top_row already advanced; bottom row sits just above it.
                    scroll_pend_d = 1'b0;
                    start_line    = 1'b1;
                    line_row      = top_row_q - ROW_W'(1);
                    state_d       = ST_CLR_LINE;
                    busy_d        = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    rx_ready_d = 1'b1;
                end
            end
            ST_CLR_LINE, ST_CLR_ALL: begin
                if (clr_done) begin
                    state_d    = ST_IDLE;
                    rx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase

        vram_ce_d = put_wr || clr_wr;
        if (put_wr) begin
            vram_ad_d  = {phys, cur_col_q};
            vram_din_d = rx_data;
        end else if (clr_wr) begin
            vram_ad_d  = clr_ad;
            vram_din_d = BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            vram_ce_q     <= 1'b0;
            vram_ad_q     <= '0;
            vram_din_q    <= '0;
            top_row_q     <= '0;
            cur_col_q     <= '0;
            cur_row_q     <= '0;
            scroll_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ready_q    <= rx_ready_d;
            busy_q        <= busy_d;
            vram_ce_q     <= vram_ce_d;
            vram_ad_q     <= vram_ad_d;
            vram_din_q    <= vram_din_d;
            top_row_q     <= top_row_d;
            cur_col_q     <= cur_col_d;
            cur_row_q     <= cur_row_d;
            scroll_pend_q <= scroll_pend_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign busy     = busy_q;
    assign vram_ce  = vram_ce_q;
    assign vram_wre = vram_ce_q;
    assign vram_ad  = vram_ad_q;
    assign vram_din = vram_din_q;
    assign top_row  = top_row_q;
    assign cur_col  = cur_col_q;
    assign cur_row  = cur_row_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_term_writer.sv
// ============================================================================
// Module      : tb_vram_term_writer
// Description : Directed self-checking bench for vram_term_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_term_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        vram_ce;
    logic        vram_wre;
    logic [10:0] vram_ad;
    logic [7:0]  vram_din;
    logic [4:0]  top_row;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [10:0] wr_ad[$];
    logic [7:0]  wr_din[$];
    int          wr_cyc[$];
    logic        wr_busy[$];

    vram_term_writer #(.COLS(64), .ROWS(32), .BLANK(8'h20)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .vram_ce  (vram_ce),
        .vram_wre (vram_wre),
        .vram_ad  (vram_ad),
        .vram_din (vram_din),
        .top_row  (top_row),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log: stamp is the number of the edge that launched the write.
    always @(negedge clk) begin
        if (vram_ce && vram_wre) begin
            wr_ad.push_back(vram_ad);
            wr_din.push_back(vram_din);
            wr_cyc.push_back(cyc);
            wr_busy.push_back(busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        wr_ad.delete();
        wr_din.delete();
        wr_cyc.delete();
        wr_busy.delete();
    endtask

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int t;
        t        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %h never accepted", b);
            rx_valid = 1'b0;
            acc      = -1;
        end else begin
            @(posedge clk);
            #1;
            acc      = cyc;
            rx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rx_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (vram_ce !== 1'b0)  begin n_fail++; $display("FAIL rst_ce: got %b want 0", vram_ce); end
        n_cmp++; if (vram_wre !== 1'b0) begin n_fail++; $display("FAIL rst_wre: got %b want 0", vram_wre); end
        n_cmp++; if (vram_ad !== 11'h0) begin n_fail++; $display("FAIL rst_ad: got %h want 000", vram_ad); end
        n_cmp++; if (vram_din !== 8'h0) begin n_fail++; $display("FAIL rst_din: got %h want 00", vram_din); end
        n_cmp++; if ({top_row, cur_col, cur_row} !== 16'h0) begin
            n_fail++; $display("FAIL rst_cursor: got top=%0d col=%0d row=%0d want 0/0/0", top_row, cur_col, cur_row);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_put_char();
        int acc;
        clear_log();
        send_byte(8'h41, acc);
        n_cmp++; if (vram_ce !== 1'b1 || vram_wre !== 1'b1) begin n_fail++; $display("FAIL put_we: got ce=%b wre=%b want 1/1", vram_ce, vram_wre); end
        n_cmp++; if (vram_ad !== 11'h000) begin n_fail++; $display("FAIL put_ad: got %h want 000", vram_ad); end
        n_cmp++; if (vram_din !== 8'h41)  begin n_fail++; $display("FAIL put_din: got %h want 41", vram_din); end
        n_cmp++; if (rx_ready !== 1'b0)   begin n_fail++; $display("FAIL put_ready_low: got %b want 0", rx_ready); end
        @(negedge clk);
        n_cmp++; if (rx_ready !== 1'b1)   begin n_fail++; $display("FAIL put_ready_back: got %b want 1", rx_ready); end
        n_cmp++; if (vram_ce !== 1'b0)    begin n_fail++; $display("FAIL put_ce_off: got %b want 0", vram_ce); end
        n_cmp++; if (cur_col !== 6'd1)    begin n_fail++; $display("FAIL put_col: got %0d want 1", cur_col); end
        n_cmp++; if (wr_ad.size() != 1)   begin n_fail++; $display("FAIL put_count: got %0d want 1", wr_ad.size()); end
    endtask

    task automatic test_line_wrap();
        int acc, first, bad;
        apply_reset();
        clear_log();
        first = 0;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(8'h21 + i), acc);
            if (i == 0) first = acc;
        end
        @(negedge clk);
        n_cmp++; if (acc - first != 126) begin n_fail++; $display("FAIL wrap_b2b_span: got %0d want 126", acc - first); end
        n_cmp++; if (wr_ad.size() != 64) begin n_fail++; $display("FAIL wrap_count: got %0d want 64", wr_ad.size()); end
        bad = 0;
        for (int i = 0; i < wr_ad.size(); i++)
            if (wr_ad[i] !== 11'(i) || wr_din[i] !== 8'(8'h21 + i)) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL wrap_addr_data: got %0d bad writes want 0", bad); end
        n_cmp++; if (wr_ad.size() > 0 && wr_ad[wr_ad.size()-1] !== 11'h03F) begin
            n_fail++; $display("FAIL wrap_last_ad: got %h want 03F", wr_ad[wr_ad.size()-1]);
        end
        n_cmp++; if (cur_col !== 6'd0 || cur_row !== 5'd1 || top_row !== 5'd0) begin
            n_fail++; $display("FAIL wrap_cursor: got col=%0d row=%0d top=%0d want 0/1/0", cur_col, cur_row, top_row);
        end
        n_cmp++; if (busy !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_idle: got busy=%b ready=%b want 0/1", busy, rx_ready); end
    endtask

    task automatic test_lf_scroll();
        int acc, n, bad;
        clear_log();
        for (int i = 0; i < 30; i++) send_byte(8'h0A, acc);
        @(negedge clk);
        n_cmp++; if (cur_row !== 5'd31 || top_row !== 5'd0) begin n_fail++; $display("FAIL lf_rows: got row=%0d top=%0d want 31/0", cur_row, top_row); end
        n_cmp++; if (wr_ad.size() != 0) begin n_fail++; $display("FAIL lf_no_write: got %0d writes want 0", wr_ad.size()); end
        clear_log();
        send_byte(8'h0A, acc);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lf_busy: got %b want 1", busy); end
        wait_ready(n);
        // Next accept edge is n+1 edges after the LF accept: 64 writes + 1.
        n_cmp++; if (n + 1 != 65) begin n_fail++; $display("FAIL lf_gap: got %0d want 65", n + 1); end
        n_cmp++; if (wr_ad.size() != 64) begin n_fail++; $display("FAIL lf_count: got %0d want 64", wr_ad.size()); end
        bad = 0;
        for (int i = 0; i < wr_ad.size(); i++)
            if (wr_ad[i] !== 11'(i) || wr_din[i] !== 8'h20 || wr_cyc[i] != acc + i) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL lf_blank_writes: got %0d bad want 0", bad); end
        n_cmp++; if (top_row !== 5'd1 || cur_row !== 5'd31 || busy !== 1'b0) begin
            n_fail++; $display("FAIL lf_after: got top=%0d row=%0d busy=%b want 1/31/0", top_row, cur_row, busy);
        end
    endtask

    task automatic test_ff_clear();
        int acc, n, bad;
        for (int i = 0; i < 4; i++) send_byte(8'h0A, acc);
        wait_ready(n);
        n_cmp++; if (top_row !== 5'd5) begin n_fail++; $display("FAIL ff_prep_top: got %0d want 5", top_row); end
        clear_log();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h61 + i), acc);
        wait_ready(n);
        bad = 0;
        for (int i = 0; i < wr_ad.size(); i++)
            if (wr_ad[i] !== 11'(12'h100 + i) || wr_din[i] !== 8'(8'h61 + i)) bad++;
        n_cmp++; if (wr_ad.size() != 10 || bad != 0) begin
            n_fail++; $display("FAIL phys_map: got %0d writes %0d bad want 10/0", wr_ad.size(), bad);
        end
        n_cmp++; if (cur_col !== 6'd10) begin n_fail++; $display("FAIL ff_prep_col: got %0d want 10", cur_col); end
        clear_log();
        send_byte(8'h0C, acc);
        n_cmp++; if (top_row !== 5'd0 || cur_col !== 6'd0 || cur_row !== 5'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ff_start: got top=%0d col=%0d row=%0d busy=%b want 0/0/0/1", top_row, cur_col, cur_row, busy);
        end
        wait_ready(n);
        n_cmp++; if (n != 2048) begin n_fail++; $display("FAIL ff_ready_gap: got %0d want 2048", n); end
        n_cmp++; if (wr_ad.size() != 2048) begin n_fail++; $display("FAIL ff_count: got %0d want 2048", wr_ad.size()); end
        bad = 0;
        for (int i = 0; i < wr_ad.size(); i++)
            if (wr_ad[i] !== 11'(i) || wr_din[i] !== 8'h20 || wr_busy[i] !== 1'b1 || wr_cyc[i] != acc + i) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ff_writes: got %0d bad want 0", bad); end
        n_cmp++; if (busy !== 1'b0 || vram_ce !== 1'b0) begin n_fail++; $display("FAIL ff_end: got busy=%b ce=%b want 0/0", busy, vram_ce); end
    endtask

    task automatic test_ctrl_codes();
        int acc, a_cr, a_bs, a_bel;
        clear_log();
        send_byte(8'h78, acc);
        send_byte(8'h79, acc);
        send_byte(8'h7A, acc);
        send_byte(8'h08, acc);
        n_cmp++; if (cur_col !== 6'd2) begin n_fail++; $display("FAIL bs_mid: got %0d want 2", cur_col); end
        send_byte(8'h0D, a_cr);
        n_cmp++; if (cur_col !== 6'd0) begin n_fail++; $display("FAIL cr_col: got %0d want 0", cur_col); end
        send_byte(8'h08, a_bs);
        n_cmp++; if (cur_col !== 6'd0) begin n_fail++; $display("FAIL bs_col0: got %0d want 0", cur_col); end
        send_byte(8'h07, a_bel);
        n_cmp++; if (cur_col !== 6'd0) begin n_fail++; $display("FAIL bel_col: got %0d want 0", cur_col); end
        send_byte(8'h7F, acc);
        send_byte(8'h9F, acc);
        @(negedge clk);
        n_cmp++; if (a_bs - a_cr != 2 || a_bel - a_bs != 2) begin
            n_fail++; $display("FAIL ctrl_cost: got %0d/%0d want 2/2", a_bs - a_cr, a_bel - a_bs);
        end
        n_cmp++; if (wr_ad.size() != 3) begin n_fail++; $display("FAIL ctrl_writes: got %0d want 3", wr_ad.size()); end
        n_cmp++; if (cur_col !== 6'd0 || cur_row !== 5'd0) begin n_fail++; $display("FAIL ctrl_cursor: got col=%0d row=%0d want 0/0", cur_col, cur_row); end
    endtask

    task automatic test_wrap_scroll();
        int acc, n, bad;
        for (int i = 0; i < 31; i++) send_byte(8'h0A, acc);
        clear_log();
        for (int i = 0; i < 64; i++) send_byte(8'(8'hA0 + i), acc);
        wait_ready(n);
        n_cmp++; if (n != 65) begin n_fail++; $display("FAIL ws_gap: got %0d want 65", n); end
        n_cmp++; if (wr_ad.size() != 128) begin n_fail++; $display("FAIL ws_count: got %0d want 128", wr_ad.size()); end
        bad = 0;
        for (int i = 0; i < wr_ad.size(); i++) begin
            if (i < 64) begin
                if (wr_ad[i] !== 11'(11'h7C0 + i) || wr_din[i] !== 8'(8'hA0 + i)) bad++;
            end else begin
                if (wr_ad[i] !== 11'(i - 64) || wr_din[i] !== 8'h20 || wr_cyc[i] != acc + i - 63) bad++;
            end
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ws_writes: got %0d bad want 0", bad); end
        n_cmp++; if (top_row !== 5'd1 || cur_row !== 5'd31 || cur_col !== 6'd0) begin
            n_fail++; $display("FAIL ws_cursor: got top=%0d row=%0d col=%0d want 1/31/0", top_row, cur_row, cur_col);
        end
    endtask

    task automatic test_reset_mid_clear();
        int acc, t;
        send_byte(8'h0C, acc);
        t = 0;
        while (!(vram_ce === 1'b1 && vram_ad === 11'd300) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++; if (t >= 3000) begin n_fail++; $display("FAIL mid_reach300: got timeout want address 300"); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (vram_wre !== 1'b0 || vram_ce !== 1'b0) begin n_fail++; $display("FAIL mid_we: got ce=%b wre=%b want 0/0", vram_ce, vram_wre); end
        n_cmp++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got ready=%b busy=%b want 1/0", rx_ready, busy); end
        n_cmp++; if (vram_ad !== 11'h0 || vram_din !== 8'h0) begin n_fail++; $display("FAIL mid_bus: got ad=%h din=%h want 000/00", vram_ad, vram_din); end
        clear_log();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (wr_ad.size() != 0) begin n_fail++; $display("FAIL mid_no_writes: got %0d want 0", wr_ad.size()); end
        n_cmp++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after: got ready=%b busy=%b want 1/0", rx_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_put_char();
        test_line_wrap();
        test_lf_scroll();
        test_ff_clear();
        test_ctrl_codes();
        test_wrap_scroll();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
